fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the fetch PC, drives the instruction memory address port and

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the fetch PC to instruction memory and queues each
// returned word with its PC in a small FIFO toward decode; redirects flush and restart.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_inst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_misaligned
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("fetch_unit: RESET_VECTOR must be 4-byte aligned");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FAULT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_fetch_pc;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_pc_mem   [FIFO_DEPTH];
  logic [31:0]       r_inst_mem [FIFO_DEPTH];
  logic              r_mis_mem  [FIFO_DEPTH];

  logic        w_valid;
  logic        w_pop;
  logic        w_push_ok;
  logic        w_push;
  logic        w_push_mis;
  logic [31:0] w_push_inst;

  // A redirect hides the head immediately so decode never consumes a flushed entry.
  assign w_valid     = (r_count != '0) && !i_redirect;
  assign w_pop       = w_valid && i_ready;
  assign w_push_ok   = (r_count < DEPTH_C) || w_pop;
  assign w_push      = !i_redirect && w_push_ok && (r_state == S_RUN || r_state == S_FAULT);
  assign w_push_mis  = (r_state == S_FAULT);
  assign w_push_inst = w_push_mis ? 32'h0 : i_imem_inst;

  assign o_imem_addr  = r_fetch_pc;
  assign o_valid      = w_valid;
  assign o_inst       = r_inst_mem[r_rd_ptr];
  assign o_pc         = r_pc_mem[r_rd_ptr];
  assign o_misaligned = r_mis_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_fetch_pc <= RESET_VECTOR;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc_mem[i[PTR_W-1:0]]   <= '0;
        r_inst_mem[i[PTR_W-1:0]] <= '0;
        r_mis_mem[i[PTR_W-1:0]]  <= 1'b0;
      end
    end else if (i_redirect) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fetch_pc <= i_redirect_pc;
      r_state    <= (i_redirect_pc[1:0] == 2'b00) ? S_RUN : S_FAULT;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
        r_inst_mem[r_wr_ptr] <= w_push_inst;
        r_mis_mem[r_wr_ptr]  <= w_push_mis;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_RUN: begin
          if (w_push_ok) r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        S_FAULT: begin
          if (w_push_ok) r_state <= S_HALT;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every negedge, plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          D  = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_inst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(D)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_imem_addr  (o_imem_addr),
    .i_imem_inst  (i_imem_inst),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_inst       (o_inst),
    .o_pc         (o_pc),
    .o_misaligned (o_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory contents: word k holds {2'b11, k}, nonzero so fault markers stand out.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b11, a[31:2]};
  endfunction

  assign i_imem_inst = mem_word(o_imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending entries and the next address to fetch.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_fault_pending;
  bit          m_halted;
  bit          m_popped;
  bit          m_room;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q.delete();
      m_pc            = RV;
      m_fault_pending = 1'b0;
      m_halted        = 1'b0;
    end else if (i_redirect) begin
      q.delete();
      m_pc            = i_redirect_pc;
      m_fault_pending = (i_redirect_pc[1:0] != 2'b00);
      m_halted        = 1'b0;
    end else begin
      m_popped = (q.size() > 0) && i_ready;
      m_room   = (q.size() < D) || m_popped;
      if (m_popped) void'(q.pop_front());
      if (!m_halted && m_room) begin
        if (m_fault_pending) begin
          q.push_back('{pc: m_pc, inst: 32'h0, mis: 1'b1});
          m_fault_pending = 1'b0;
          m_halted        = 1'b1;
        end else begin
          q.push_back('{pc: m_pc, inst: mem_word(m_pc), mis: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    chk("model_addr", o_imem_addr, m_pc);
    chk("model_valid", {31'b0, o_valid}, {31'b0, (q.size() > 0) && !i_redirect});
    if (o_valid && q.size() > 0) begin
      chk("model_pc", o_pc, q[0].pc);
      chk("model_inst", o_inst, q[0].inst);
      chk("model_mis", {31'b0, o_misaligned}, {31'b0, q[0].mis});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  logic [47:0] rdy_pat;

  initial begin
    i_rst_n       = 1'b0;
    i_ready       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    rdy_pat       = 48'hB3F0_5A7C_E91D;

    // Scenario 1: reset state, then one instruction per cycle.
    #12;
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_mis", {31'b0, o_misaligned}, 32'h0);
    i_rst_n = 1'b1;
    tick(1);
    chk("s1_first_valid", {31'b0, o_valid}, 32'h1);
    chk("s1_first_pc", o_pc, 32'h0);
    chk("s1_addr", o_imem_addr, 32'h4);
    tick(3);
    chk("s1_pc3", o_pc, 32'hC);
    chk("s1_inst3", o_inst, 32'hC000_0003);

    // Scenario 2: backpressure fills the buffer and freezes fetch.
    i_ready = 1'b0;
    tick(5);
    chk("s2_hold_pc", o_pc, 32'hC);
    chk("s2_hold_addr", o_imem_addr, 32'h14);
    chk("s2_hold_valid", {31'b0, o_valid}, 32'h1);
    i_ready = 1'b1;
    tick(1);
    chk("s2_rel_pc1", o_pc, 32'h10);
    tick(1);
    chk("s2_rel_pc2", o_pc, 32'h14);

    // Scenario 3: redirect while full and ready.
    i_ready = 1'b0;
    tick(2);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    i_ready       = 1'b1;
    #1;
    chk("s3_redir_valid", {31'b0, o_valid}, 32'h0);
    tick(1);
    i_redirect = 1'b0;
    chk("s3_empty_valid", {31'b0, o_valid}, 32'h0);
    chk("s3_addr", o_imem_addr, 32'h100);
    tick(1);
    chk("s3_target_valid", {31'b0, o_valid}, 32'h1);
    chk("s3_target_pc", o_pc, 32'h100);
    chk("s3_target_inst", o_inst, 32'hC000_0040);

    // Scenario 4: misaligned target yields one fault marker, then halts.
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h102;
    tick(1);
    i_redirect = 1'b0;
    chk("s4_addr", o_imem_addr, 32'h102);
    tick(1);
    chk("s4_fault_valid", {31'b0, o_valid}, 32'h1);
    chk("s4_fault_pc", o_pc, 32'h102);
    chk("s4_fault_mis", {31'b0, o_misaligned}, 32'h1);
    chk("s4_fault_inst", o_inst, 32'h0);
    tick(4);
    chk("s4_halt_valid", {31'b0, o_valid}, 32'h0);
    chk("s4_halt_addr", o_imem_addr, 32'h102);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    tick(1);
    i_redirect = 1'b0;
    tick(1);
    chk("s4_resume_pc", o_pc, 32'h200);
    chk("s4_resume_mis", {31'b0, o_misaligned}, 32'h0);

    // Scenario 5: address wraps past the top of the space.
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    tick(1);
    i_redirect = 1'b0;
    tick(1);
    chk("s5_pc0", o_pc, 32'hFFFF_FFF8);
    tick(1);
    chk("s5_pc1", o_pc, 32'hFFFF_FFFC);
    tick(1);
    chk("s5_wrap_pc", o_pc, 32'h0);
    chk("s5_wrap_inst", o_inst, 32'hC000_0000);

    // Mixed backpressure and redirects, checked by the model.
    for (int k = 0; k < 48; k++) begin
      i_ready = rdy_pat[k];
      if (k == 10) begin
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
      end else if (k == 25) begin
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h301;
      end else if (k == 35) begin
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h80;
      end else begin
        i_redirect = 1'b0;
      end
      tick(1);
    end
    i_redirect = 1'b0;
    i_ready    = 1'b1;
    tick(3);

    // Scenario 6: asynchronous reset between edges.
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("s6_valid", {31'b0, o_valid}, 32'h0);
    chk("s6_addr", o_imem_addr, RV);
    chk("s6_pc", o_pc, 32'h0);
    chk("s6_inst", o_inst, 32'h0);
    #2;
    i_rst_n = 1'b1;
    tick(1);
    chk("s6_first_pc", o_pc, 32'h0);
    chk("s6_first_valid", {31'b0, o_valid}, 32'h1);
    tick(1);
    chk("s6_second_pc", o_pc, 32'h4);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
